// File: rtl/store_checker.sv
// store_checker: ordered store monitor on the data-memory write port with a cycle timeout.
// Optional macro STORE_CHECKER_STRICT_EN: a store to an address outside the in-use slots fails with code 3.
module store_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 150
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [WIDTH-1:0]         ld_adr,
    input  logic [WIDTH-1:0]         ld_data,
    input  logic [$clog2(DEPTH):0]   num_exp,
    input  logic                     start,
    input  logic                     MemWrite,
    input  logic [WIDTH-1:0]         DataAdr,
    input  logic [WIDTH-1:0]         WriteData,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [1:0]               fail_code,
    output logic [WIDTH-1:0]         fail_adr,
    output logic [WIDTH-1:0]         fail_data,
    output logic [$clog2(DEPTH):0]   match_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int NW = IW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_DATA    = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT = 2'd2;
    localparam logic [1:0] CODE_ADDR    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NW-1:0]      num_q, num_d;
    logic [NW-1:0]      match_q, match_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         fail_code_q, fail_code_d;
    logic [WIDTH-1:0]   fail_adr_q, fail_adr_d;
    logic [WIDTH-1:0]   fail_data_q, fail_data_d;
    logic               busy_q, done_q, pass_q;
    logic [WIDTH-1:0]   adr_q  [DEPTH];
    logic [WIDTH-1:0]   data_q [DEPTH];

    logic               ld_ok_s;
    logic [IW-1:0]      ptr_s;
    logic               adr_hit_s;
    logic               data_hit_s;
    logic               last_s;
    logic               timeout_s;
    logic [NW-1:0]      num_clamp_s;

    // The match count doubles as the ordered-check pointer; it stays below num_q while running.
    assign ptr_s       = match_q[IW-1:0];
    assign ld_ok_s     = ld_en && (state_q != S_RUN) && ({1'b0, ld_idx} < NW'(DEPTH));
    assign adr_hit_s   = MemWrite && (DataAdr == adr_q[ptr_s]);
    assign data_hit_s  = (WriteData == data_q[ptr_s]);
    assign last_s      = (match_q == (num_q - NW'(1)));
    assign timeout_s   = (cnt_q == CW'(TIMEOUT - 1));
    assign num_clamp_s = ((num_exp == {NW{1'b0}}) || (num_exp > NW'(DEPTH))) ? NW'(DEPTH) : num_exp;

`ifdef STORE_CHECKER_STRICT_EN
    logic any_hit_s;

    // Does the store address belong to any in-use slot?
    always_comb begin
        any_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_hit_s = any_hit_s | ((NW'(i) < num_q) && (adr_q[i] == DataAdr));
        end
    end
`endif

    // Expected-store table, writable outside RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= {WIDTH{1'b0}};
                data_q[i] <= {WIDTH{1'b0}};
            end
        end else if (ld_ok_s) begin
            adr_q[ld_idx]  <= ld_adr;
            data_q[ld_idx] <= ld_data;
        end
    end

    // Next-state and verdict logic.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        match_d     = match_q;
        cnt_d       = cnt_q;
        fail_code_d = fail_code_q;
        fail_adr_d  = fail_adr_q;
        fail_data_d = fail_data_q;
        case (state_q)
            S_IDLE, S_PASS, S_FAIL: begin
                if (start) begin
                    state_d     = S_RUN;
                    num_d       = num_clamp_s;
                    match_d     = {NW{1'b0}};
                    cnt_d       = {CW{1'b0}};
                    fail_code_d = CODE_NONE;
                    fail_adr_d  = {WIDTH{1'b0}};
                    fail_data_d = {WIDTH{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (adr_hit_s && data_hit_s) begin
                    match_d = match_q + NW'(1);
                end else begin
                    match_d = match_q;
                end
                // A final match outranks a timeout; a bad store outranks it too.
                if (adr_hit_s && data_hit_s && last_s) begin
                    state_d = S_PASS;
                end else if (adr_hit_s && !data_hit_s) begin
                    state_d     = S_FAIL;
                    fail_code_d = CODE_DATA;
                    fail_adr_d  = DataAdr;
                    fail_data_d = WriteData;
`ifdef STORE_CHECKER_STRICT_EN
                end else if (MemWrite && !adr_hit_s && !any_hit_s) begin
                    state_d     = S_FAIL;
                    fail_code_d = CODE_ADDR;
                    fail_adr_d  = DataAdr;
                    fail_data_d = WriteData;
`endif
                end else if (timeout_s) begin
                    state_d     = S_FAIL;
                    fail_code_d = CODE_TIMEOUT;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            num_q       <= {NW{1'b0}};
            match_q     <= {NW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            fail_code_q <= CODE_NONE;
            fail_adr_q  <= {WIDTH{1'b0}};
            fail_data_q <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            match_q     <= match_d;
            cnt_q       <= cnt_d;
            fail_code_q <= fail_code_d;
            fail_adr_q  <= fail_adr_d;
            fail_data_q <= fail_data_d;
            busy_q      <= (state_d == S_RUN);
            done_q      <= (state_d == S_PASS) || (state_d == S_FAIL);
            pass_q      <= (state_d == S_PASS);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fail_code_q;
    assign fail_adr  = fail_adr_q;
    assign fail_data = fail_data_q;
    assign match_cnt = match_q;

endmodule

// File: tb/tb_store_checker.sv
// Self-checking bench for store_checker: directed scenarios plus randomized traffic against a list-based model.
module tb_store_checker;

    localparam int W = 32;
    localparam int D = 4;
    localparam int T = 150;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         ld_en     = 1'b0;
    logic [1:0]   ld_idx    = 2'd0;
    logic [W-1:0] ld_adr    = '0;
    logic [W-1:0] ld_data   = '0;
    logic [2:0]   num_exp   = 3'd0;
    logic         start     = 1'b0;
    logic         MemWrite  = 1'b0;
    logic [W-1:0] DataAdr   = '0;
    logic [W-1:0] WriteData = '0;
    logic         busy, done, pass;
    logic [1:0]   fail_code;
    logic [W-1:0] fail_adr, fail_data;
    logic [2:0]   match_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    store_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_idx(ld_idx), .ld_adr(ld_adr),
        .ld_data(ld_data), .num_exp(num_exp), .start(start), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData), .busy(busy), .done(done), .pass(pass),
        .fail_code(fail_code), .fail_adr(fail_adr), .fail_data(fail_data), .match_cnt(match_cnt)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 run, 2 pass, 3 fail; m_cyc = cycles elapsed since start.
    int           m_mode = 0;
    int           m_num  = 0;
    int           m_ptr  = 0;
    int           m_cyc  = 0;
    int           m_code = 0;
    logic [W-1:0] m_fa   = '0;
    logic [W-1:0] m_fd   = '0;
    logic [W-1:0] m_adr [D] = '{default: '0};
    logic [W-1:0] m_dat [D] = '{default: '0};

    function automatic bit in_list(input logic [W-1:0] a);
        for (int j = 0; j < m_num; j++)
            if (m_adr[j] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit hit;
        if (reset) begin
            m_mode = 0; m_num = 0; m_ptr = 0; m_cyc = 0; m_code = 0; m_fa = '0; m_fd = '0;
            for (int j = 0; j < D; j++) begin m_adr[j] = '0; m_dat[j] = '0; end
        end else if (m_mode != 1) begin
            if (ld_en) begin m_adr[ld_idx] = ld_adr; m_dat[ld_idx] = ld_data; end
            if (start) begin
                m_num  = (num_exp == 0 || num_exp > D) ? D : int'(num_exp);
                m_mode = 1; m_ptr = 0; m_cyc = 0; m_code = 0; m_fa = '0; m_fd = '0;
            end
        end else begin
            m_cyc++;
            hit = MemWrite && (DataAdr == m_adr[m_ptr]);
            if (hit && WriteData == m_dat[m_ptr]) begin
                m_ptr++;
                if (m_ptr == m_num) m_mode = 2;
            end else if (hit) begin
                m_mode = 3; m_code = 1; m_fa = DataAdr; m_fd = WriteData;
`ifdef STORE_CHECKER_STRICT_EN
            end else if (MemWrite && !in_list(DataAdr)) begin
                m_mode = 3; m_code = 3; m_fa = DataAdr; m_fd = WriteData;
`endif
            end
            if (m_mode == 1 && m_cyc >= T) begin m_mode = 3; m_code = 2; end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("busy", busy, (m_mode == 1));
        chk("done", done, (m_mode >= 2));
        chk("pass", pass, (m_mode == 2));
        chk("fail_code", fail_code, m_code);
        chk("fail_adr", fail_adr, m_fa);
        chk("fail_data", fail_data, m_fd);
        chk("match_cnt", match_cnt, m_ptr);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int a, input int d);
        ld_en = 1'b1; ld_idx = idx[1:0]; ld_adr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic go(input int n);
        num_exp = n[2:0]; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input int a, input int d);
        MemWrite = 1'b1; DataAdr = a; WriteData = d;
        tick();
        MemWrite = 1'b0;
    endtask

    initial begin
        int n;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_code", fail_code, 0); chk("rst_match", match_cnt, 0);

        // Single expected store, arriving a few cycles in.
        load(0, 128, 254); go(1);
        chk("t1_busy", busy, 1);
        repeat (4) tick();
        store(128, 254);
        chk("t1_pass", pass, 1); chk("t1_match", match_cnt, 1); chk("t1_code", fail_code, 0);

        // Data mismatch.
        load(0, 128, 254); go(1); store(128, 255);
        chk("t2_code", fail_code, 1); chk("t2_adr", fail_adr, 128);
        chk("t2_data", fail_data, 255); chk("t2_pass", pass, 0);

        // Interleaved foreign store.
        load(0, 100, 7); load(1, 128, 254); go(2);
        store(100, 7); store(64, 9);
`ifdef STORE_CHECKER_STRICT_EN
        chk("t3_code", fail_code, 3); chk("t3_adr", fail_adr, 64); chk("t3_data", fail_data, 9);
`else
        store(128, 254);
        chk("t3_pass", pass, 1); chk("t3_match", match_cnt, 2);
`endif

        // Timeout exactly T cycles after start; last-cycle match still passes.
        load(0, 128, 254); go(1);
        n = 0;
        while (!done && n < 300) begin tick(); n++; end
        chk("t4_cycles", n, T); chk("t4_code", fail_code, 2); chk("t4_adr", fail_adr, 0);
        go(1); repeat (T - 1) tick(); store(128, 254);
        chk("t4_late_pass", pass, 1);
        go(1); repeat (T) tick();
        chk("t4_after_code", fail_code, 2);

        // Reset mid-run clears everything including the slot table.
        load(0, 100, 7); load(1, 128, 254); go(2); store(100, 7);
        chk("t5_match", match_cnt, 1);
        reset = 1'b1; #2;
        chk("t5_busy", busy, 0); chk("t5_match0", match_cnt, 0); chk("t5_done", done, 0);
        tick(); reset = 1'b0; tick();
        go(1); store(0, 0);
        chk("t5_cleared_pass", pass, 1);
        load(0, 100, 7); load(1, 128, 254); go(2); store(100, 7); store(128, 254);
        chk("t5_rerun_pass", pass, 1);

        // num_exp = 0 means all slots.
        for (int i = 0; i < D; i++) load(i, 10 + i, 20 + i);
        go(0);
        for (int i = 0; i < D - 1; i++) store(10 + i, 20 + i);
        chk("t6_done3", done, 0); chk("t6_match3", match_cnt, 3);
        store(13, 23);
        chk("t6_pass", pass, 1); chk("t6_match4", match_cnt, 4);

        // Randomized traffic, checked every cycle by the compare process.
        repeat (3000) begin
            ld_en     = ($urandom_range(0, 3) == 0);
            ld_idx    = 2'($urandom_range(0, 3));
            ld_adr    = $urandom_range(0, 7);
            ld_data   = $urandom_range(0, 3);
            start     = ($urandom_range(0, 24) == 0);
            num_exp   = 3'($urandom_range(0, 7));
            MemWrite  = $urandom_range(0, 1) == 1;
            DataAdr   = $urandom_range(0, 7);
            WriteData = $urandom_range(0, 3);
            reset     = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; ld_en = 1'b0; start = 1'b0; MemWrite = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
